load_store_unit: RTL and testbench

//  Data-memory access stage of core_l1. Accepts one load/store per request, drives the word-aligned data bus,
//  and handles the bus handshake. For loads it extracts the addressed byte/half/word lane, right-justified.
//  It emits that lane as unextended_data together with the sx_op code that selects the extension.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per request, bus handshake with timeout,
// and right-justified load-lane extraction with the sign/zero-extension code for signext.

package isa_shared;
  typedef enum logic [4:0] {
    SX_0700  = 5'b00001,
    SX_1500  = 5'b00010,
    SX_3100  = 5'b00100,
    SXU_0700 = 5'b01000,
    SXU_1500 = 5'b10000
  } sx_op_e;
endpackage

module load_store_unit
  import isa_shared::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] unextended_data,
  output logic [4:0]            sx_op,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           tmo_q;
  logic                    is_store_q;
  logic [2:0]              funct3_q;
  logic [1:0]              lane_q;

  logic                    accept;
  logic                    legal;
  logic                    timeout;
  logic                    capture;
  logic                    fault_d;
  logic [3:0]              strb;
  logic [DATA_WIDTH-1:0]   wdata_rep;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   lane_data;
  sx_op_e                  sx_code;

  assign accept  = (state_q == IDLE) && req_valid;
  assign timeout = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  // Legality and store-lane formatting are decided from the live request at accept time.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal     = 1'b0;
    strb      = 4'b1111;
    wdata_rep = req_wdata;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = !req_is_store;
      3'b101:  legal = !req_is_store && !req_addr[0];
      default: legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << req_addr[1:0];
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {lane_q, 3'b000};
    lane_data = shifted;
    sx_code   = SX_3100;
    case (funct3_q[1:0])
      2'b00:   lane_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      2'b01:   lane_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: lane_data = shifted;
    endcase
    case (funct3_q)
      3'b000:  sx_code = SX_0700;
      3'b001:  sx_code = SX_1500;
      3'b100:  sx_code = SXU_0700;
      3'b101:  sx_code = SXU_1500;
      default: sx_code = SX_3100;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    capture = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    mem_req = (state_q == REQ);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = legal ? REQ : DONE;
          fault_d = !legal;
        end
      end
      REQ: begin
        // A response arriving with the grant, or on the final cycle, beats the timeout.
        if (mem_gnt && mem_rvalid) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (timeout) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
          capture = 1'b1;
        end else if (timeout) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q           <= '0;
      is_store_q      <= 1'b0;
      funct3_q        <= 3'b000;
      lane_q          <= 2'b00;
      fault           <= 1'b0;
      unextended_data <= '0;
      sx_op           <= SX_3100;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= 4'b0000;
    end else begin
      if (accept) begin
        tmo_q      <= '0;
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        lane_q     <= req_addr[1:0];
        mem_we     <= req_is_store;
        mem_addr   <= {req_addr[DATA_WIDTH-1:2], 2'b00};
        mem_wdata  <= req_is_store ? wdata_rep : '0;
        mem_wstrb  <= req_is_store ? strb : 4'b0000;
      end else if (state_q == REQ || state_q == WAIT) begin
        tmo_q <= tmo_q + CW'(1);
      end
      if (state_d == DONE && state_q != DONE) fault <= fault_d;
      if (capture && !is_store_q) begin
        unextended_data <= lane_data;
        sx_op           <= sx_code;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// checked against a cycle-timeline reference model of the access rules.

module tb_load_store_unit;
  import isa_shared::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] unextended_data;
  logic [4:0]  sx_op;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_unext;
  logic [4:0]  exp_sx;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .busy            (busy),
    .done            (done),
    .fault           (fault),
    .unextended_data (unextended_data),
    .sx_op           (sx_op),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] sx_for(input logic [2:0] f3);
    case (f3)
      3'b000:  return SX_0700;
      3'b001:  return SX_1500;
      3'b100:  return SXU_0700;
      3'b101:  return SXU_1500;
      default: return SX_3100;
    endcase
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal_of(input bit st, input logic [2:0] f3);
    return (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  task automatic check_reset_values(input string tag);
    check1({tag, "_busy"},    busy, 1'b0);
    check1({tag, "_done"},    done, 1'b0);
    check1({tag, "_fault"},   fault, 1'b0);
    check1({tag, "_mem_req"}, mem_req, 1'b0);
    check1({tag, "_mem_we"},  mem_we, 1'b0);
    check32({tag, "_mem_addr"},  mem_addr, 32'h0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check32({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
    check32({tag, "_unext"},     unextended_data, 32'h0);
    check32({tag, "_sx_op"},     32'(sx_op), 32'(SX_3100));
  endtask

  // Called at a negedge with the DUT idle. g = REQ-relative cycle of the grant,
  // r = cycle of the response (r == g means same cycle, r < 0 means never).
  task automatic run_access(input string tag, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int g, input int r);
    int          n;
    int          a;
    int          done_c;
    bit          ok;
    logic [31:0] lane;
    logic [31:0] wexp;
    logic [3:0]  sexp;

    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    req_valid = 1'b0;

    n = size_of(f3);
    a = int'(addr[1:0]);

    if (!legal_of(st, f3) || (a % n) != 0) begin
      check1({tag, "_flt_done"},  done, 1'b1);
      check1({tag, "_flt_fault"}, fault, 1'b1);
      check1({tag, "_flt_req"},   mem_req, 1'b0);
      check1({tag, "_flt_busy"},  busy, 1'b1);
      @(negedge clk);
      check1({tag, "_flt_idle_busy"}, busy, 1'b0);
      check1({tag, "_flt_idle_done"}, done, 1'b0);
      check32({tag, "_flt_unext"}, unextended_data, exp_unext);
      check32({tag, "_flt_sx"},    32'(sx_op), 32'(exp_sx));
      return;
    end

    lane = 32'h0;
    wexp = 32'h0;
    sexp = 4'b0000;
    for (int k = 0; k < n; k++) lane[8*k +: 8] = rdata[8*(a+k) +: 8];
    for (int i = 0; i < 4; i++) begin
      wexp[8*i +: 8] = wdata[8*(i % n) +: 8];
      sexp[i]        = st && (i >= a) && (i < a + n);
    end

    ok     = (r >= 0) && (r <= TO - 1);
    done_c = ok ? r + 1 : TO;

    for (int c = 0; c <= done_c; c++) begin
      if (c < done_c) begin
        check1({tag, "_done_early"}, done, 1'b0);
        check1({tag, "_busy"},       busy, 1'b1);
        check1({tag, "_mem_req"},    mem_req, (c <= g));
        if (c <= g) begin
          check32({tag, "_mem_addr"},  mem_addr, {addr[31:2], 2'b00});
          check1({tag, "_mem_we"},     mem_we, st);
          check32({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(sexp));
          if (st) check32({tag, "_mem_wdata"}, mem_wdata, wexp);
        end
        mem_gnt      = (c == g);
        mem_rvalid   = (c == r);
        mem_rdata    = (c == r) ? rdata : $urandom;
        req_valid    = 1'($urandom_range(0, 1));
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom;
        req_wdata    = $urandom;
      end else begin
        check1({tag, "_done"},     done, 1'b1);
        check1({tag, "_fault"},    fault, !ok);
        check1({tag, "_done_req"}, mem_req, 1'b0);
        check1({tag, "_done_busy"}, busy, 1'b1);
        mem_gnt    = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        req_valid  = 1'b0;
      end
      @(negedge clk);
    end

    if (ok && !st) begin
      exp_unext = lane;
      exp_sx    = sx_for(f3);
    end
    check1({tag, "_idle_busy"}, busy, 1'b0);
    check1({tag, "_idle_done"}, done, 1'b0);
    check32({tag, "_unext"}, unextended_data, exp_unext);
    check32({tag, "_sx_op"}, 32'(sx_op), 32'(exp_sx));

    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    check1({tag, "_stray_busy"}, busy, 1'b0);
    check1({tag, "_stray_req"},  mem_req, 1'b0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    int          g;
    int          r;
    int          m;
    logic [2:0]  legal_f3 [5];

    legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    exp_unext    = 32'h0;
    exp_sx       = SX_3100;

    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    run_access("lb",      1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0, 1);
    run_access("sh",      1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h5555_5555, 1, 2);
    run_access("lw_mis",  1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         0, 1);
    run_access("lhu",     1'b0, 3'b101, 32'h0000_0042, 32'h0,         32'hFEDC_1234, 3, 4);
    run_access("tmo",     1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h1111_1111, 0, -1);
    run_access("same",    1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'h00C3_7F00, 2, 2);
    run_access("sbu_ill", 1'b1, 3'b100, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         0, 1);
    run_access("f011",    1'b0, 3'b011, 32'h0000_0040, 32'h0,         32'h0,         0, 1);
    run_access("tmo_req", 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,         20, 20);
    run_access("last",    1'b0, 3'b001, 32'h0000_0502, 32'h0,         32'h8001_7FFE, 3, TO - 1);

    // Reset while waiting for the response: the access is dropped and a late response ignored.
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    check1("rst_req", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check1("rst_wait_busy", busy, 1'b1);
    check1("rst_wait_req",  mem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("rst_mid");
    for (int k = 0; k < 4; k++) begin
      check1("rst_no_done", done, 1'b0);
      check1("rst_no_busy", busy, 1'b0);
      mem_rvalid = (k == 1);
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    exp_unext  = 32'h0;
    exp_sx     = SX_3100;
    check32("rst_late_unext", unextended_data, exp_unext);
    run_access("lw_after", 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h1357_9BDF, 0, 1);

    for (int t = 0; t < 60; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom_range(0, 7));
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 3);
      m = $urandom_range(0, 7);
      if (m == 0)     r = -1;
      else if (m < 3) r = g;
      else            r = g + $urandom_range(1, 5);
      run_access("rnd", st, f3, $urandom, $urandom, $urandom, g, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
